frame_sched: RTL and testbench

FRAME_SCHED -- requirements
Module: frame_sched

---
 rtl/frame_sched_pkg.sv | 22 ++
 rtl/frame_wdog.sv | 33 +++
 rtl/frame_sched.sv | 182 ++++++++++++++++++
 tb/tb_frame_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding, handshake
// pulse width and a counter-width helper used by the top and the watchdog.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_RUN     = 3'd2,
    ST_WAIT_UP = 3'd3,
    ST_FINISH  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Width in cycles of the UPSTR and UPENDR handshake pulses.
  localparam int unsigned PULSE_CYCLES = 1;

  // Counter width for a count range of n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_wdog.sv
// Idle-stream watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CYCLES-1.
module frame_wdog
  import frame_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Saturates at the limit so a stalled parent can never wrap it back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: sequences start/end handshakes for the stream input and
// up-sampler, checks row lengths, counts frames and raises a sticky irq.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int unsigned SRC_IMG_WIDTH  = 3840,
  parameter int unsigned SRC_IMG_HEIGHT = 2160,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic       s_axis_aclk,
  input  logic       s_axis_rst,
  input  logic       cfg_start,
  input  logic [7:0] cfg_frames,
  input  logic       cfg_abort,
  input  logic       irq_clr,
  input  logic       in_hsk,
  input  logic       in_last,
  input  logic       upsp_frame_done,
  output logic       UPSTR,
  output logic       UPENDR,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic       irq,
  output logic       err_len,
  output logic       err_timeout
);

  localparam int unsigned COL_W = cnt_w(SRC_IMG_WIDTH);
  localparam int unsigned ROW_W = cnt_w(SRC_IMG_HEIGHT);
  localparam int unsigned PW    = cnt_w(PULSE_CYCLES + 1);

  localparam logic [COL_W:0]   ROW_BEATS  = (COL_W+1)'(SRC_IMG_WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(SRC_IMG_HEIGHT - 1);
  localparam logic [PW-1:0]    PULSE_LOAD = PW'(PULSE_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       remaining;
  logic             cont;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PW-1:0]    upstr_left;
  logic [PW-1:0]    upendr_left;
  logic             upstr_trig;
  logic             upendr_trig;
  logic             in_frame;
  logic             abort_take;
  logic             tout_take;
  logic             beat_run;
  logic             row_end;
  logic             wd_clear;
  logic             wd_expired;

  assign in_frame   = (state == ST_RUN) || (state == ST_WAIT_UP);
  assign abort_take = cfg_abort && (state != ST_IDLE);
  assign tout_take  = !abort_take && in_frame && wd_expired;
  assign beat_run   = (state == ST_RUN) && in_hsk;
  assign row_end    = beat_run && in_last;
  assign wd_clear   = in_hsk || (state_nxt != state);

  frame_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (s_axis_aclk),
    .rst    (s_axis_rst),
    .clear  (wd_clear),
    .enable (in_frame),
    .expired(wd_expired)
  );

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort outranks the watchdog, which outranks normal sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cfg_start) state_nxt = ST_ARM;
      ST_ARM:     state_nxt = ST_RUN;
      ST_RUN: begin
        if (upsp_frame_done) begin
          state_nxt = ST_FINISH;
        end else if (row_end && (row == LAST_ROW)) begin
          state_nxt = ST_WAIT_UP;
        end
      end
      ST_WAIT_UP: if (upsp_frame_done) state_nxt = ST_FINISH;
      ST_FINISH:  state_nxt = (cont || (remaining > 8'd1)) ? ST_ARM : ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (abort_take || tout_take) begin
      state_nxt = ST_IDLE;
    end
  end

  // FINISH already owns an UPENDR pulse, so an abort there adds no second one.
  always_comb begin
    upstr_trig  = (state_nxt == ST_ARM);
    upendr_trig = (state_nxt == ST_FINISH) ||
                  ((abort_take || tout_take) && (state != ST_FINISH));
    busy        = (state != ST_IDLE);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_rst) begin
      upstr_left  <= '0;
      upendr_left <= '0;
    end else begin
      if (upstr_trig) begin
        upstr_left <= PULSE_LOAD;
      end else if (upstr_left != '0) begin
        upstr_left <= upstr_left - PW'(1);
      end
      if (upendr_trig) begin
        upendr_left <= PULSE_LOAD;
      end else if (upendr_left != '0) begin
        upendr_left <= upendr_left - PW'(1);
      end
    end
  end

  assign UPSTR  = (upstr_left != '0);
  assign UPENDR = (upendr_left != '0);

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_rst) begin
      remaining   <= '0;
      cont        <= 1'b0;
      frame_cnt   <= '0;
      col         <= '0;
      row         <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && cfg_start) begin
        remaining   <= cfg_frames;
        cont        <= (cfg_frames == 8'd0);
        frame_cnt   <= '0;
        err_len     <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (state == ST_ARM) begin
        col <= '0;
        row <= '0;
      end
      if (beat_run) begin
        if (in_last) begin
          col <= '0;
          row <= row + ROW_W'(1);
          if (({1'b0, col} + (COL_W+1)'(1)) != ROW_BEATS) begin
            err_len <= 1'b1;
          end
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if ((state == ST_FINISH) && !abort_take) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (remaining != 8'd0) begin
          remaining <= remaining - 8'd1;
        end
      end
      if (tout_take) begin
        err_timeout <= 1'b1;
      end
      // A new interrupt source wins over a clear in the same cycle.
      if ((state == ST_DONE) || abort_take || tout_take) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched with a small geometry (4x2, timeout 16);
// expectations come from a frame-level model of the scheduler's rules.
module tb_frame_sched;

  localparam int W = 4;
  localparam int H = 2;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic [7:0] cfg_frames;
  logic       cfg_abort;
  logic       irq_clr;
  logic       in_hsk;
  logic       in_last;
  logic       upsp_frame_done;
  logic       UPSTR;
  logic       UPENDR;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       irq;
  logic       err_len;
  logic       err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int   upstr_seen   = 0;
  int   upendr_seen  = 0;
  int   overlap_seen = 0;
  int   irq_rise     = 0;
  logic irq_prev     = 1'b0;

  always #5 clk = ~clk;

  frame_sched #(
    .SRC_IMG_WIDTH (W),
    .SRC_IMG_HEIGHT(H),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_rst     (rst),
    .cfg_start      (cfg_start),
    .cfg_frames     (cfg_frames),
    .cfg_abort      (cfg_abort),
    .irq_clr        (irq_clr),
    .in_hsk         (in_hsk),
    .in_last        (in_last),
    .upsp_frame_done(upsp_frame_done),
    .UPSTR          (UPSTR),
    .UPENDR         (UPENDR),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .irq            (irq),
    .err_len        (err_len),
    .err_timeout    (err_timeout)
  );

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (UPSTR === 1'b1) upstr_seen++;
    if (UPENDR === 1'b1) upendr_seen++;
    if ((UPSTR === 1'b1) && (UPENDR === 1'b1)) overlap_seen++;
    if ((irq === 1'b1) && (irq_prev !== 1'b1)) irq_rise++;
    irq_prev = irq;
  end

  // Reference model: a row is in error when its beat count differs from W.
  function automatic int model_row_err(input int len);
    return (len != W) ? 1 : 0;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_upstr(output int ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (UPSTR === 1'b1) begin
        ok = 1;
        break;
      end
      cycle();
    end
  endtask

  task automatic wait_idle(output int ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
      cycle();
    end
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    cycle();
    irq_clr = 1'b0;
    cycle();
  endtask

  // Entered in RUN; returns on the cycle the scheduler shows FINISH.
  task automatic drive_frame(input int l0, input int l1, input int maxgap, input int coincide);
    int lens[2];
    int g;
    lens[0] = l0;
    lens[1] = l1;
    for (int r = 0; r < H; r++) begin
      for (int b = 0; b < lens[r]; b++) begin
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) cycle();
        in_hsk  = 1'b1;
        in_last = (b == lens[r] - 1);
        if ((coincide != 0) && (r == H - 1) && (b == lens[r] - 1)) upsp_frame_done = 1'b1;
        cycle();
        in_hsk  = 1'b0;
        in_last = 1'b0;
      end
    end
    if (coincide == 0) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) cycle();
      upsp_frame_done = 1'b1;
      cycle();
    end
    upsp_frame_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_start = 1'b0; cfg_frames = 8'd0; cfg_abort = 1'b0; irq_clr = 1'b0;
    in_hsk = 1'b0; in_last = 1'b0; upsp_frame_done = 1'b0;
    repeat (3) cycle();
    n_cmp++; if (UPSTR !== 1'b0) begin n_bad++; $display("FAIL reset_upstr got=%b exp=0", UPSTR); end
    n_cmp++; if (UPENDR !== 1'b0) begin n_bad++; $display("FAIL reset_upendr got=%b exp=0", UPENDR); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL reset_err_len got=%b exp=0", err_len); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err_timeout got=%b exp=0", err_timeout); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single_frame();
    int s0, e0, ok;
    clear_irq();
    s0 = upstr_seen; e0 = upendr_seen;
    cfg_frames = 8'd1; cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    n_cmp++; if (UPSTR !== 1'b1) begin n_bad++; $display("FAIL single_upstr_latency got=%b exp=1", UPSTR); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    cycle();
    drive_frame(W, W, 0, 0);
    n_cmp++; if (UPENDR !== 1'b1) begin n_bad++; $display("FAIL single_upendr got=%b exp=1", UPENDR); end
    wait_idle(ok);
    cycle();
    n_cmp++; if (ok != 1) begin n_bad++; $display("FAIL single_idle got=busy exp=idle"); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL single_frame_cnt got=%0d exp=1", frame_cnt); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL single_irq got=%b exp=1", irq); end
    n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL single_err_len got=%b exp=0", err_len); end
    n_cmp++; if (upstr_seen - s0 != 1) begin n_bad++; $display("FAIL single_upstr_count got=%0d exp=1", upstr_seen - s0); end
    n_cmp++; if (upendr_seen - e0 != 1) begin n_bad++; $display("FAIL single_upendr_count got=%0d exp=1", upendr_seen - e0); end
  endtask

  task automatic test_multi_frame();
    int n, s0, e0, r0, o0, ok, ok2;
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 3 : int'($urandom_range(4, 2));
      clear_irq();
      s0 = upstr_seen; e0 = upendr_seen; r0 = irq_rise; o0 = overlap_seen;
      cfg_frames = 8'(n); cfg_start = 1'b1;
      cycle();
      cfg_start = 1'b0;
      ok = 0;
      for (int f = 0; f < n; f++) begin
        wait_upstr(ok);
        if (ok == 0) break;
        cycle();
        if (f == 0) begin
          cfg_start = 1'b1; cfg_frames = 8'd0;
          cycle();
          cfg_start = 1'b0; cfg_frames = 8'(n);
        end
        drive_frame(W, W, 3, int'($urandom_range(1, 0)));
        n_cmp++; if (UPENDR !== 1'b1) begin n_bad++; $display("FAIL multi_upendr_f%0d got=%b exp=1", f, UPENDR); end
      end
      n_cmp++; if (ok != 1) begin n_bad++; $display("FAIL multi_upstr_wait got=none exp=pulse"); end
      wait_idle(ok2);
      cycle();
      n_cmp++; if (ok2 != 1) begin n_bad++; $display("FAIL multi_idle got=busy exp=idle"); end
      n_cmp++; if (frame_cnt !== 8'(n)) begin n_bad++; $display("FAIL multi_frame_cnt got=%0d exp=%0d", frame_cnt, n); end
      n_cmp++; if (upstr_seen - s0 != n) begin n_bad++; $display("FAIL multi_upstr_count got=%0d exp=%0d", upstr_seen - s0, n); end
      n_cmp++; if (upendr_seen - e0 != n) begin n_bad++; $display("FAIL multi_upendr_count got=%0d exp=%0d", upendr_seen - e0, n); end
      n_cmp++; if (irq_rise - r0 != 1) begin n_bad++; $display("FAIL multi_irq_rises got=%0d exp=1", irq_rise - r0); end
      n_cmp++; if (overlap_seen - o0 != 0) begin n_bad++; $display("FAIL multi_overlap got=%0d exp=0", overlap_seen - o0); end
    end
  endtask

  task automatic test_len_err();
    int l0, l1, exp_err, ok;
    for (int it = 0; it < 6; it++) begin
      l0 = (it == 0) ? 3 : int'($urandom_range(W, 1));
      l1 = (it == 0) ? W : int'($urandom_range(W, 1));
      exp_err = (model_row_err(l0) + model_row_err(l1) > 0) ? 1 : 0;
      clear_irq();
      cfg_frames = 8'd1; cfg_start = 1'b1;
      cycle();
      cfg_start = 1'b0;
      cycle();
      drive_frame(l0, l1, 2, 0);
      wait_idle(ok);
      cycle();
      n_cmp++; if (err_len !== 1'(exp_err)) begin n_bad++; $display("FAIL len_err_%0d rows=%0d,%0d got=%b exp=%0d", it, l0, l1, err_len, exp_err); end
      n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL len_frame_cnt_%0d got=%0d exp=1", it, frame_cnt); end
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL len_irq_%0d got=%b exp=1", it, irq); end
    end
  endtask

  task automatic test_timeout();
    int e0, n, found, ok;
    clear_irq();
    e0 = upendr_seen;
    cfg_frames = 8'd1; cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    n = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n++;
      if (UPENDR === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL tout_upendr got=none exp=pulse"); end
    n_cmp++; if ((n < T) || (n > T + 1)) begin n_bad++; $display("FAIL tout_latency got=%0d exp=%0d..%0d", n, T, T + 1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tout_busy got=%b exp=0", busy); end
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL tout_err got=%b exp=1", err_timeout); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL tout_irq got=%b exp=1", irq); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL tout_frame_cnt got=%0d exp=0", frame_cnt); end
    cycle();
    n_cmp++; if (upendr_seen - e0 != 1) begin n_bad++; $display("FAIL tout_upendr_count got=%0d exp=1", upendr_seen - e0); end
    // Long but sub-limit gaps must not trip the watchdog.
    cfg_frames = 8'd1; cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    cycle();
    drive_frame(W, W, T - 4, 0);
    wait_idle(ok);
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL slow_err_timeout got=%b exp=0", err_timeout); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL slow_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_abort();
    int e0, o0;
    clear_irq();
    e0 = upendr_seen;
    cfg_abort = 1'b1;
    cycle();
    cfg_abort = 1'b0;
    cycle();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_abort_busy got=%b exp=0", busy); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL idle_abort_irq got=%b exp=0", irq); end
    n_cmp++; if (upendr_seen - e0 != 0) begin n_bad++; $display("FAIL idle_abort_upendr got=%0d exp=0", upendr_seen - e0); end
    e0 = upendr_seen; o0 = overlap_seen;
    cfg_frames = 8'd2; cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    cycle();
    in_hsk = 1'b1;
    repeat (int'($urandom_range(6, 1))) cycle();
    in_hsk = 1'b0;
    cfg_abort = 1'b1; upsp_frame_done = 1'b1;
    cycle();
    cfg_abort = 1'b0; upsp_frame_done = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (UPENDR !== 1'b1) begin n_bad++; $display("FAIL abort_upendr got=%b exp=1", UPENDR); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL abort_irq got=%b exp=1", irq); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL abort_frame_cnt got=%0d exp=0", frame_cnt); end
    cycle();
    n_cmp++; if (UPENDR !== 1'b0) begin n_bad++; $display("FAIL abort_upendr_width got=%b exp=0", UPENDR); end
    n_cmp++; if (upendr_seen - e0 != 1) begin n_bad++; $display("FAIL abort_upendr_count got=%0d exp=1", upendr_seen - e0); end
    n_cmp++; if (overlap_seen - o0 != 0) begin n_bad++; $display("FAIL abort_overlap got=%0d exp=0", overlap_seen - o0); end
  endtask

  task automatic test_reset_restart();
    int k, s0, e0, ok;
    e0 = upendr_seen;
    cfg_frames = 8'd2; cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    cycle();
    in_hsk = 1'b1;
    repeat (5) cycle();
    in_hsk = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_mid_irq got=%b exp=0", irq); end
    cycle();
    cycle();
    n_cmp++; if (upendr_seen - e0 != 0) begin n_bad++; $display("FAIL rst_mid_upendr got=%0d exp=0", upendr_seen - e0); end
    k = int'($urandom_range(5, 3));
    s0 = upstr_seen; e0 = upendr_seen;
    cfg_frames = 8'd0; cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    ok = 0;
    for (int f = 0; f < k; f++) begin
      wait_upstr(ok);
      if (ok == 0) break;
      cycle();
      drive_frame(W, W, 2, int'($urandom_range(1, 0)));
    end
    if (ok == 1) wait_upstr(ok);
    n_cmp++; if (ok != 1) begin n_bad++; $display("FAIL cont_upstr_wait got=none exp=pulse"); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cont_busy got=%b exp=1", busy); end
    n_cmp++; if (frame_cnt !== 8'(k)) begin n_bad++; $display("FAIL cont_frame_cnt got=%0d exp=%0d", frame_cnt, k); end
    cycle();
    cfg_abort = 1'b1;
    cycle();
    cfg_abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_abort_busy got=%b exp=0", busy); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL cont_abort_irq got=%b exp=1", irq); end
    cycle();
    n_cmp++; if (upstr_seen - s0 != k + 1) begin n_bad++; $display("FAIL cont_upstr_count got=%0d exp=%0d", upstr_seen - s0, k + 1); end
    n_cmp++; if (upendr_seen - e0 != k + 1) begin n_bad++; $display("FAIL cont_upendr_count got=%0d exp=%0d", upendr_seen - e0, k + 1); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_len_err();
    test_timeout();
    test_abort();
    test_reset_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
